// File: rtl/noc_output_port.sv
// Per-direction NoC output stage: flit mux, registered link, one-hot turn token, credit flow control.
// Optional NOC_OUT_STATS_EN adds accepted-flit and stall-cycle counters.
module noc_output_port #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CREDITS = 4,
  localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        port_select,
  input  logic              port_enable,
  input  logic [DATA_W-1:0] N_data_i,
  input  logic [DATA_W-1:0] S_data_i,
  input  logic [DATA_W-1:0] E_data_i,
  input  logic [DATA_W-1:0] W_data_i,
  input  logic [DATA_W-1:0] L_data_i,
  input  logic              credit_in,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              port_full,
  output logic [4:0]        turn,
`ifdef NOC_OUT_STATS_EN
  output logic [15:0]       flit_cnt_o,
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              err_o
);

  localparam logic [CW-1:0] CreditsMax = CW'(CREDITS);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CW-1:0]     r_credits;
  logic [4:0]        r_turn;
  logic              r_err;

  logic              w_sel_ok;
  logic              w_no_credit;
  logic              w_accept;
  logic              w_err_set;
  logic [DATA_W-1:0] w_sel_flit;
  logic [CW-1:0]     w_credits_d;

  always_comb begin
    w_sel_ok    = (port_select <= 3'd4);
    w_no_credit = (r_credits == '0);
    w_accept    = port_enable && !w_no_credit && w_sel_ok;
  end

  always_comb begin
    w_sel_flit = '0;
    case (port_select)
      3'd0:    w_sel_flit = N_data_i;
      3'd1:    w_sel_flit = S_data_i;
      3'd2:    w_sel_flit = E_data_i;
      3'd3:    w_sel_flit = W_data_i;
      3'd4:    w_sel_flit = L_data_i;
      default: w_sel_flit = '0;
    endcase
  end

  // A simultaneous accept and credit return cancel; a lone credit return saturates at CREDITS.
  always_comb begin
    w_credits_d = r_credits;
    if (w_accept && !credit_in) begin
      w_credits_d = r_credits - CW'(1);
    end else if (credit_in && !w_accept && (r_credits != CreditsMax)) begin
      w_credits_d = r_credits + CW'(1);
    end
  end

  always_comb begin
    w_err_set = (port_enable && (w_no_credit || !w_sel_ok)) ||
                (credit_in && !w_accept && (r_credits == CreditsMax));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_credits <= CreditsMax;
      r_turn    <= 5'b10000;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= w_sel_flit;
      end
      r_valid   <= w_accept;
      r_credits <= w_credits_d;
      r_turn    <= {r_turn[0], r_turn[4:1]};
      r_err     <= r_err | w_err_set;
    end
  end

`ifdef NOC_OUT_STATS_EN
  logic [15:0] r_flit_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_flit_cnt <= r_flit_cnt + 16'd1;
      end
      if (port_enable && w_no_credit) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign flit_cnt_o  = r_flit_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

  assign data_o    = r_data;
  assign valid_o   = r_valid;
  assign port_full = w_no_credit;
  assign turn      = r_turn;
  assign err_o     = r_err;

endmodule

// File: tb/tb_noc_output_port.sv
// Self-checking bench for noc_output_port: directed scenarios plus randomized traffic
// compared against a behavioural credit/token model.
module tb_noc_output_port;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CREDITS = 4;

  logic              clk;
  logic              rst_n;
  logic [2:0]        port_select;
  logic              port_enable;
  logic [DATA_W-1:0] din [5];
  logic              credit_in;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              port_full;
  logic [4:0]        turn;
  logic              err_o;
`ifdef NOC_OUT_STATS_EN
  logic [15:0]       flit_cnt_o;
  logic [15:0]       stall_cnt_o;
`endif

  noc_output_port #(
    .DATA_W  (DATA_W),
    .CREDITS (CREDITS)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port_select (port_select),
    .port_enable (port_enable),
    .N_data_i    (din[0]),
    .S_data_i    (din[1]),
    .E_data_i    (din[2]),
    .W_data_i    (din[3]),
    .L_data_i    (din[4]),
    .credit_in   (credit_in),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .port_full   (port_full),
    .turn        (turn),
`ifdef NOC_OUT_STATS_EN
    .flit_cnt_o  (flit_cnt_o),
    .stall_cnt_o (stall_cnt_o),
`endif
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_cred;
  int          m_turn_idx;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_err;
  int          m_flit;
  int          m_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred     = CREDITS;
    m_turn_idx = 0;
    m_data     = '0;
    m_valid    = 1'b0;
    m_err      = 1'b0;
    m_flit     = 0;
    m_stall    = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".data"},  32'(data_o),    32'(m_data));
    check_eq({tag, ".valid"}, 32'(valid_o),   32'(m_valid));
    check_eq({tag, ".full"},  32'(port_full), 32'(m_cred == 0));
    check_eq({tag, ".turn"},  32'(turn),      32'(5'b10000 >> m_turn_idx));
    check_eq({tag, ".err"},   32'(err_o),     32'(m_err));
`ifdef NOC_OUT_STATS_EN
    check_eq({tag, ".fcnt"},  32'(flit_cnt_o),  32'(m_flit % 65536));
    check_eq({tag, ".scnt"},  32'(stall_cnt_o), 32'(m_stall % 65536));
`endif
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare.
  task automatic cycle(input string tag, input logic en, input logic [2:0] sel, input logic cin);
    logic acc;
    port_enable = en;
    port_select = sel;
    credit_in   = cin;
    acc = en && (m_cred > 0) && (sel <= 3'd4);
    @(posedge clk);
    #1;
    if (en && (m_cred == 0 || sel > 3'd4)) m_err = 1'b1;
    if (cin && !acc && m_cred == CREDITS) m_err = 1'b1;
    if (en && m_cred == 0) m_stall++;
    if (acc) begin
      m_data = din[sel];
      m_flit++;
    end
    m_valid = acc;
    m_cred  = m_cred - int'(acc) + int'(cin);
    if (m_cred > CREDITS) m_cred = CREDITS;
    m_turn_idx = (m_turn_idx + 1) % 5;
    check_all(tag);
  endtask

  // Asynchronous assertion between edges, held across one edge, released away from the edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    port_select = '0;
    port_enable = 1'b0;
    credit_in   = 1'b0;
    for (int i = 0; i < 5; i++) din[i] = 8'h00;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle turn rotation
    for (int i = 0; i < 6; i++) cycle("idle", 1'b0, 3'd0, 1'b0);

    // Single accept from E
    din[2] = 8'h23;
    cycle("e_acc", 1'b1, 3'd2, 1'b0);
    cycle("e_idle", 1'b0, 3'd0, 1'b0);
    do_reset("r1");

    // Drain all credits from N, then overflow attempt
    for (int i = 0; i < 4; i++) begin
      din[0] = 8'h11 + 8'(i);
      cycle("n_burst", 1'b1, 3'd0, 1'b0);
    end
    cycle("n_full", 1'b1, 3'd0, 1'b0);
    // Credit return with enable at zero credits: no forward, credits -> 1
    cycle("cr_zero", 1'b1, 3'd1, 1'b1);
    din[1] = 8'hA5;
    cycle("after_cr", 1'b1, 3'd1, 1'b0);
    do_reset("r2");

    // Two accepts -> credits 2, then accept with credit return, then illegal select
    din[3] = 8'h3C;
    cycle("w_acc1", 1'b1, 3'd3, 1'b0);
    cycle("w_acc2", 1'b1, 3'd3, 1'b0);
    din[4] = 8'h5A;
    cycle("l_both", 1'b1, 3'd4, 1'b1);
    cycle("bad_sel", 1'b1, 3'd6, 1'b0);
    cycle("hold2", 1'b1, 3'd4, 1'b0);
    cycle("hold1", 1'b1, 3'd4, 1'b0);
    cycle("hold0", 1'b1, 3'd4, 1'b0);
    do_reset("r3");

    // Credit return at full credits saturates and flags an error
    cycle("sat", 1'b0, 3'd0, 1'b1);
    cycle("sat_acc", 1'b1, 3'd0, 1'b0);
    do_reset("r4");

    // Mid-stream reset with valid_o=1 and one credit left
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h70 + 8'(i);
      cycle("pre_rst", 1'b1, 3'(i), 1'b0);
    end
    check_eq("mid.valid", 32'(valid_o), 32'd1);
    do_reset("r5");
    for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 3'd4, 1'b0);
    check_eq("post.full", 32'(port_full), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       en;
      logic       cin;
      logic [2:0] sel;
      for (int i = 0; i < 5; i++) din[i] = 8'($urandom);
      en  = ($urandom_range(0, 9) < 6);
      cin = ($urandom_range(0, 9) < 4);
      sel = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle("rand", en, sel, cin);
      if (n % 400 == 399) do_reset("rrand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
